shannon_envelope: RTL
=====================

# shannon_envelope

Downstream consumer of the low-pass stage in the HSS chain. Takes the filtered signed fixed-point sample stream, computes per-sample energy (x² rescaled to the same fixed-point format), and averages it over non-overlapping windows of 2^WIN_LOG2 samples. Emits one envelope value per window to the segmentation logic through a valid/ready handshake, with overrun detection.

## Interface
- DATA_W, 32: input sample width, signed.
- FRAC_BITS, 10: fractional bits of the fixed-point format; shared with the low-pass stage.
- WIN_LOG2, 5: log2 of window length (default 32 samples); legal range 1..8.
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  filtered sample, signed, FRAC_BITS fractional.
- data_valid  in  1  sample strobe; one sample consumed per cycle it is high.
- en  in  1  block enable; low discards any partial window.
- clr_ovr  in  1  clears the overrun flag.
- env_data  out  DATA_W  window mean energy, unsigned value in [0, 2^(DATA_W-1)-1].
- env_valid  out  1  env_data holds an unconsumed result.
- env_ready  in  1  consumer accepts env_data when env_valid & env_ready.
- ovr  out  1  sticky: a result was overwritten before being consumed.

## Operation
- Stage S1 (square): on data_valid & en, sq <= (data_in * data_in) >>> FRAC_BITS. The full 2·DATA_W product is taken, then saturated to 2^(DATA_W-1)-1. sq_v <= data_valid & en.
- Stage S2 (accumulate): accumulator is DATA_W+WIN_LOG2 bits and unsigned, so it cannot overflow. The sample counter is WIN_LOG2 bits.
  - On sq_v: acc <= acc + sq and cnt <= cnt + 1.
  - When cnt == 2^WIN_LOG2-1 on sq_v, the window closes: result = (acc + sq) >> WIN_LOG2, acc <= 0, cnt wraps to 0, and load <= 1.
- Output register: on load, env_data <= result and env_valid <= 1.
  - If env_valid was 1 and env_ready was 0 in that cycle, set ovr <= 1. The old value is lost and the newest result wins.
  - Handshake without load: env_valid & env_ready clears env_valid.
  - Handshake and load in the same cycle: the new value is loaded, env_valid stays 1, and ovr is not set.
- en low: clear acc, cnt, sq_v and load. The output register and ovr are held.
- clr_ovr: ovr <= 0. If clr_ovr and an overrun event occur in the same cycle, the set wins.
- Mid-operation reset: RST aborts the partial window and any in-flight S1/S2 data.
- Gaps in data_valid are allowed. A window is defined by sample count, not cycles.
- Small-signal case: negative samples square to positive values. Results below 1 LSB after the shift truncate to 0.

## Timing
- Reset values: env_data=0, env_valid=0, ovr=0. Internal acc=0, cnt=0, sq_v=0, load=0.
- Latency: the last sample of a window is presented with data_valid in cycle t. It is squared in t+1, and the result is in the load register in t+2. env_valid is first observed high in t+3.
- Throughput: one sample per cycle sustained. Back-to-back windows need no bubbles.
- env_data is stable while env_valid & !env_ready, unless an overrun load occurs.
- No combinational path from env_ready to env_valid or env_data.

## Structure
- Shared package/header (shared with the low-pass stage): FRAC_BITS and the DATA_W default, and the saturation maximum constant 2^(DATA_W-1)-1.
- Natural sub-module: sat_square, combinational. It takes a signed DATA_W input and produces the shifted, saturated DATA_W energy. It is reused by other energy-based stages.
- The accumulator, counter and output/handshake register stay in the top module. No FSM beyond the counter and the valid flag.

## Test plan
- Constant input: 32 samples of data_in=1024 (1.0), data_valid every cycle, env_ready=1 → exactly one env_valid pulse with env_data=1024, 3 cycles after the 32nd sample.
- Sign and mixed values: 16× -2048 then 16× 1024 → env_data=(16·4096+16·1024)/32=2560.
- Saturation: 32× 0x7FFFFFFF → env_data=0x7FFFFFFF, no wrap.
- Backpressure and overrun: env_ready=0 for 64 samples, with window values 1024 then 4096 → env_data=4096, ovr=1. Then pulse clr_ovr → ovr=0. Then env_ready=1 → handshake completes and env_valid drops.
- Simultaneous handshake and load: env_ready pulsed high exactly in the load cycle of the second window → env_data updates, env_valid stays 1, ovr stays 0.
- Reset mid-window and gapped input: 10 samples of 5000, then RST for 1 cycle, then 32 samples of 1024 with data_valid every other cycle → first env_data=1024. A separate en deassert mid-window behaves identically.

Source files
------------

// File: rtl/shannon_envelope_pkg.sv
// Fixed-point constants shared by the HSS low-pass and energy stages.
package shannon_envelope_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int FRAC_BITS_DEF = 10;

  // Largest positive value of a signed DATA_W_DEF sample: 2^(DATA_W-1)-1.
  localparam logic [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};

endpackage

// File: rtl/shannon_envelope_sat_square.sv
// Combinational energy of one fixed-point sample: (x*x) >>> FRAC_BITS, saturated.
module shannon_envelope_sat_square
  import shannon_envelope_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic signed [DATA_W-1:0] x,
  output logic        [DATA_W-1:0] energy
);

  localparam logic [2*DATA_W-1:0] MAX_WIDE = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]   MAX_OUT  = {1'b0, {(DATA_W-1){1'b1}}};

  logic signed [2*DATA_W-1:0] prod;
  logic        [2*DATA_W-1:0] shifted;

  // The square is never negative, so an unsigned compare after the shift is safe.
  always_comb begin
    prod    = x * x;
    shifted = prod >>> FRAC_BITS;
    energy  = (shifted > MAX_WIDE) ? MAX_OUT : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/shannon_envelope.sv
// Windowed mean-energy envelope with valid/ready output and sticky overrun flag.
module shannon_envelope
  import shannon_envelope_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int WIN_LOG2  = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid,
  input  logic                     en,
  input  logic                     clr_ovr,
  output logic        [DATA_W-1:0] env_data,
  output logic                     env_valid,
  input  logic                     env_ready,
  output logic                     ovr
);

  localparam int ACC_W = DATA_W + WIN_LOG2;

  logic [DATA_W-1:0]   sq_next;
  logic [DATA_W-1:0]   sq;
  logic                sq_v;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [WIN_LOG2-1:0] cnt;
  logic                load;
  logic [DATA_W-1:0]   result;
  logic                load_now;
  logic                ovr_set;

  shannon_envelope_sat_square #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat_square (
    .x      (data_in),
    .energy (sq_next)
  );

  assign acc_sum = acc + {{WIN_LOG2{1'b0}}, sq};

  always_ff @(posedge CLK) begin
    if (RST) begin
      sq     <= '0;
      result <= '0;
    end else begin
      if (data_valid && en) sq <= sq_next;
      if (en && sq_v && (cnt == '1)) result <= acc_sum[ACC_W-1:WIN_LOG2];
    end
  end

  // Disabling the block drops the partial window and anything in flight.
  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      sq_v <= 1'b0;
      acc  <= '0;
      cnt  <= '0;
      load <= 1'b0;
    end else begin
      sq_v <= data_valid;
      load <= 1'b0;
      if (sq_v) begin
        cnt <= cnt + 1'b1;
        if (cnt == '1) begin
          acc  <= '0;
          load <= 1'b1;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  assign load_now = en && load;
  assign ovr_set  = load_now && env_valid && !env_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      env_data  <= '0;
      env_valid <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      if (load_now) begin
        env_data  <= result;
        env_valid <= 1'b1;
      end else if (env_valid && env_ready) begin
        env_valid <= 1'b0;
      end
      if (ovr_set)      ovr <= 1'b1;
      else if (clr_ovr) ovr <= 1'b0;
    end
  end

endmodule
